// File: rtl/seq_pkg.sv
// Shared encodings for the serial bit transmitter and the sequence detector benches.
package seq_pkg;

  // State encodings, also referenced by the detector benches.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = IDLE,
    StShift = SHIFT,
    StGap   = GAP
  } tx_state_e;

  // Line level when no frame bit is being driven.
  localparam logic IDLE_BIT_DEFAULT = 1'b0;

endpackage

// File: rtl/seq_bit_tx_shreg.sv
// Load/shift register for the transmitter. On load the used field is left-aligned
// so bit len-1 lands on the MSB; that first bit leaves immediately through load_msb_o
// and the register keeps only the bits still to be sent.
module seq_bit_tx_shreg #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LW    = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [LW-1:0]    len_i,
  output logic             load_msb_o,
  output logic             shift_msb_o
);

  logic [WIDTH-1:0] aligned;
  logic [WIDTH-1:0] data_q, data_d;
  logic [LW-1:0]    shamt;

  // Left-align the used field; bits above len-1 fall off the top.
  always_comb begin
    shamt   = LW'(WIDTH) - len_i;
    aligned = data_i << shamt;
  end

  assign load_msb_o  = aligned[WIDTH-1];
  assign shift_msb_o = data_q[WIDTH-1];

  // Next contents: load drops the bit already sent, shift advances one position.
  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = {aligned[WIDTH-2:0], 1'b0};
    end else if (shift_i) begin
      data_d = {data_q[WIDTH-2:0], 1'b0};
    end
  end

  // Shift register storage with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/seq_bit_tx.sv
// Serial bit-stream transmitter: accepts a word plus bit count over valid/ready,
// sends the used bits MSB-first one per clock, then idles GAP_CYCLES cycles.
module seq_bit_tx
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned GAP_CYCLES = 2,
  parameter logic        IDLE_BIT   = IDLE_BIT_DEFAULT,
  parameter int unsigned LW         = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LW-1:0]    in_len,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             tx_done,
  output logic             busy
);

  localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GapLoad = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  tx_state_e     state_q, state_d;
  logic [LW-1:0] bit_cnt_q, bit_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          tx_done_q, tx_done_d;
  logic [LW-1:0] len_clamp;
  logic          load, shift;
  logic          load_msb, shift_msb;

  assign len_clamp  = (in_len > LW'(WIDTH)) ? LW'(WIDTH) : in_len;
  // Gated by reset so nothing looks acceptable while reset is held.
  assign in_ready   = (state_q == StIdle) && rst;
  assign busy       = (state_q != StIdle);
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign tx_done    = tx_done_q;

  seq_bit_tx_shreg #(
    .WIDTH (WIDTH),
    .LW    (LW)
  ) u_shreg (
    .clk_i       (clk),
    .rst_ni      (rst),
    .load_i      (load),
    .shift_i     (shift),
    .data_i      (in_data),
    .len_i       (len_clamp),
    .load_msb_o  (load_msb),
    .shift_msb_o (shift_msb)
  );

  // Next state, counters and registered-output values.
  // bit_cnt_q counts bits still to send after the one currently on dout.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    dout_d       = IDLE_BIT;
    dout_valid_d = 1'b0;
    tx_done_d    = 1'b0;
    load         = 1'b0;
    shift        = 1'b0;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (len_clamp == '0) begin
            tx_done_d = 1'b1;
          end else begin
            load         = 1'b1;
            state_d      = StShift;
            bit_cnt_d    = len_clamp - LW'(1);
            dout_d       = load_msb;
            dout_valid_d = 1'b1;
            tx_done_d    = (len_clamp == LW'(1));
          end
        end
      end
      StShift: begin
        if (bit_cnt_q == '0) begin
          state_d   = (GAP_CYCLES > 0) ? StGap : StIdle;
          gap_cnt_d = GapLoad;
        end else begin
          shift        = 1'b1;
          bit_cnt_d    = bit_cnt_q - LW'(1);
          dout_d       = shift_msb;
          dout_valid_d = 1'b1;
          tx_done_d    = (bit_cnt_q == LW'(1));
        end
      end
      StGap: begin
        if (gap_cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset drops any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      dout_q       <= IDLE_BIT;
      dout_valid_q <= 1'b0;
      tx_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      tx_done_q    <= tx_done_d;
    end
  end

endmodule

// File: tb/tb_seq_bit_tx.sv
// Directed self-checking bench for seq_bit_tx (WIDTH=16, GAP_CYCLES=2, IDLE_BIT=0).
module tb_seq_bit_tx;

  localparam int unsigned W   = 16;
  localparam int unsigned GAP = 2;
  localparam int unsigned LW  = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_data;
  logic [LW-1:0] in_len;
  logic          in_valid;
  logic          in_ready;
  logic          dout;
  logic          dout_valid;
  logic          tx_done;
  logic          busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0]  data;
    logic [LW-1:0] len;
    int            n;      // bits expected on the line
    logic [W-1:0]  exp;    // expected bits, exp[n-1] sent first
  } frame_t;

  frame_t vecs [7];

  seq_bit_tx #(
    .WIDTH      (W),
    .GAP_CYCLES (GAP),
    .IDLE_BIT   (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_len     (in_len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .tx_done    (tx_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Send one frame and check every cycle until the transmitter is ready again.
  // pulse_at >= 0 raises in_valid with a different word during that bit.
  task automatic run_frame(input logic [W-1:0] data, input logic [LW-1:0] len,
                           input int n, input logic [W-1:0] exp, input int pulse_at);
    in_data  = data;
    in_len   = len;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (n == 0) begin
      check("len0_done", tx_done, 1'b1);
      check("len0_valid", dout_valid, 1'b0);
      check("len0_ready", in_ready, 1'b1);
      check("len0_busy", busy, 1'b0);
      tick();
      check("len0_done_clr", tx_done, 1'b0);
      check("len0_valid2", dout_valid, 1'b0);
    end else begin
      for (int k = 0; k < n; k++) begin
        if (k == pulse_at) begin
          in_valid = 1'b1;
          in_data  = 16'h0003;
          in_len   = 5'd2;
        end
        check("bit_valid", dout_valid, 1'b1);
        check("bit_val", dout, exp[n-1-k]);
        check("bit_done", tx_done, (k == n - 1));
        check("bit_busy", busy, 1'b1);
        check("bit_ready", in_ready, 1'b0);
        tick();
        in_valid = 1'b0;
      end
      for (int g = 0; g < int'(GAP); g++) begin
        check("gap_valid", dout_valid, 1'b0);
        check("gap_dout", dout, 1'b0);
        check("gap_done", tx_done, 1'b0);
        check("gap_ready", in_ready, 1'b0);
        tick();
      end
      check("end_ready", in_ready, 1'b1);
      check("end_busy", busy, 1'b0);
      check("end_valid", dout_valid, 1'b0);
    end
  endtask

  logic       b2b_valid [14];
  logic       b2b_dout  [14];
  logic       b2b_done  [14];

  initial begin
    vecs[0] = '{data: 16'h000A, len: 5'd4,  n: 4,  exp: 16'h000A};
    vecs[1] = '{data: 16'h8001, len: 5'd20, n: 16, exp: 16'h8001};
    vecs[2] = '{data: 16'hFFF5, len: 5'd3,  n: 3,  exp: 16'h0005};
    vecs[3] = '{data: 16'h1234, len: 5'd0,  n: 0,  exp: 16'h0000};
    vecs[4] = '{data: 16'hFFFF, len: 5'd1,  n: 1,  exp: 16'h0001};
    vecs[5] = '{data: 16'hABCD, len: 5'd16, n: 16, exp: 16'hABCD};
    vecs[6] = '{data: 16'h00F0, len: 5'd8,  n: 8,  exp: 16'h00F0};

    // Stream for 000A then 0005 with in_valid held: 4 bits, 2 gap, 1 ready, 4 bits.
    b2b_valid = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0};
    b2b_dout  = '{1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0};
    b2b_done  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};

    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h000A;
    in_len   = 5'd4;

    // Reset held two cycles with a pending request.
    tick();
    check("rst_ready1", in_ready, 1'b0);
    tick();
    check("rst_ready2", in_ready, 1'b0);
    check("rst_valid", dout_valid, 1'b0);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check("rel_dout", dout, 1'b0);
    check("rel_valid", dout_valid, 1'b0);
    check("rel_done", tx_done, 1'b0);
    check("rel_busy", busy, 1'b0);
    check("rel_ready", in_ready, 1'b1);

    // Table of single frames.
    foreach (vecs[i]) begin
      run_frame(vecs[i].data, vecs[i].len, vecs[i].n, vecs[i].exp, -1);
    end

    // Back-to-back with in_valid held.
    in_data  = 16'h000A;
    in_len   = 5'd4;
    in_valid = 1'b1;
    tick();
    in_data  = 16'h0005;
    for (int i = 0; i < 14; i++) begin
      check("b2b_valid", dout_valid, b2b_valid[i]);
      check("b2b_dout", dout, b2b_dout[i]);
      check("b2b_done", tx_done, b2b_done[i]);
      if (i == 6) check("b2b_ready6", in_ready, 1'b1);
      if (i == 5) check("b2b_ready5", in_ready, 1'b0);
      tick();
      if (i == 6) in_valid = 1'b0;
    end

    // Mid-frame reset after three bits of an F0 frame.
    in_data  = 16'h00F0;
    in_len   = 5'd8;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("mid_bit", dout, 1'b1);
      check("mid_valid", dout_valid, 1'b1);
      if (k < 2) tick();
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid_rst_valid", dout_valid, 1'b0);
    check("mid_rst_done", tx_done, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_dout", dout, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("mid_quiet_valid", dout_valid, 1'b0);
      check("mid_quiet_done", tx_done, 1'b0);
    end
    run_frame(16'h000A, 5'd4, 4, 16'h000A, -1);

    // Request during SHIFT is ignored and not queued.
    run_frame(16'h00F0, 5'd8, 8, 16'h00F0, 2);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("ign_valid", dout_valid, 1'b0);
      check("ign_busy", busy, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
